// File: rtl/temporal_compare_array.sv
// Multi-channel gamma-cycle temporal comparator: each channel compares the first
// rising-edge arrival times of a and b and emits a fixed-width pulse when the selected relation holds.
module temporal_compare_array #(
  parameter int N_CH              = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int CW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [N_CH-1:0]      a,
  input  logic [N_CH-1:0]      b,
  output logic [N_CH-1:0]      q,
  output logic [N_CH*CW-1:0]   q_time,
  output logic                 gamma_start,
  output logic [CW-1:0]        gamma_cnt
);

  localparam int PW_W = $clog2(PULSE_WIDTH + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [PW_W-1:0] PW_LOAD  = PW_W'(PULSE_WIDTH);

  localparam logic [1:0] MODE_LTE = 2'd0;
  localparam logic [1:0] MODE_LT  = 2'd1;
  localparam logic [1:0] MODE_EQ  = 2'd2;

  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [1:0]                     mode_q, mode_d;
  logic [N_CH-1:0]                a_prev_q, b_prev_q;
  logic [N_CH-1:0]                a_seen_q, a_seen_d;
  logic [N_CH-1:0]                b_seen_q, b_seen_d;
  logic [N_CH-1:0]                fired_q, fired_d;
  logic [N_CH-1:0][CW-1:0]        qt_q, qt_d;
  logic [N_CH-1:0][PW_W-1:0]      pc_q, pc_d;

  logic [N_CH-1:0] as_eff, bs_eff, fd_eff, ea, eb, first_a, first_b, fire;

  assign gamma_start = en & (cnt_q == '0);
  assign gamma_cnt   = cnt_q;
  assign q_time      = qt_q;

  // The mode sampled at a boundary already governs events arriving in that boundary cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    mode_d = gamma_start ? mode : mode_q;
  end

  always_comb begin
    as_eff   = '0;
    bs_eff   = '0;
    fd_eff   = '0;
    ea       = '0;
    eb       = '0;
    first_a  = '0;
    first_b  = '0;
    fire     = '0;
    a_seen_d = a_seen_q;
    b_seen_d = b_seen_q;
    fired_d  = fired_q;
    qt_d     = qt_q;
    pc_d     = pc_q;
    q        = '0;
    for (int i = 0; i < N_CH; i++) begin
      as_eff[i]  = a_seen_q[i] & ~gamma_start;
      bs_eff[i]  = b_seen_q[i] & ~gamma_start;
      fd_eff[i]  = fired_q[i]  & ~gamma_start;
      ea[i]      = en & a[i] & ~a_prev_q[i];
      eb[i]      = en & b[i] & ~b_prev_q[i];
      first_a[i] = ea[i] & ~as_eff[i];
      first_b[i] = eb[i] & ~bs_eff[i];
      case (mode_d)
        MODE_LTE: fire[i] = first_a[i] & ~bs_eff[i];
        MODE_LT:  fire[i] = first_a[i] & ~bs_eff[i] & ~first_b[i];
        MODE_EQ:  fire[i] = first_a[i] & first_b[i];
        default:  fire[i] = (first_a[i] & ~bs_eff[i]) | (first_b[i] & ~as_eff[i]);
      endcase
      fire[i]     = fire[i] & ~fd_eff[i];
      a_seen_d[i] = as_eff[i] | ea[i];
      b_seen_d[i] = bs_eff[i] | eb[i];
      fired_d[i]  = fd_eff[i] | fire[i];
      if (fire[i]) qt_d[i] = cnt_q;
      if (fire[i])                pc_d[i] = PW_LOAD;
      else if (gamma_start)       pc_d[i] = '0;
      else if (pc_q[i] != '0)     pc_d[i] = pc_q[i] - 1'b1;
      // A pulse still counting at a boundary is cut off in the boundary cycle itself.
      q[i] = (pc_q[i] != '0) & ~gamma_start;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mode_q   <= MODE_LTE;
      a_prev_q <= '0;
      b_prev_q <= '0;
      a_seen_q <= '0;
      b_seen_q <= '0;
      fired_q  <= '0;
      qt_q     <= '0;
      pc_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      a_prev_q <= a;
      b_prev_q <= b;
      a_seen_q <= a_seen_d;
      b_seen_q <= b_seen_d;
      fired_q  <= fired_d;
      qt_q     <= qt_d;
      pc_q     <= pc_d;
    end
  end

endmodule

// File: tb/tb_temporal_compare_array.sv
// Scoreboard bench for temporal_compare_array: a driver pushes expected outputs from an
// arrival-time reference model; a negedge monitor pops and compares.
module tb_temporal_compare_array;
  localparam int N_CH = 4;
  localparam int G    = 16;
  localparam int PW   = 8;
  localparam int CW   = 4;

  logic                clk = 1'b0;
  logic                rst_n, en;
  logic [1:0]          mode;
  logic [N_CH-1:0]     a, b, q;
  logic [N_CH*CW-1:0]  q_time;
  logic                gamma_start;
  logic [CW-1:0]       gamma_cnt;

  temporal_compare_array #(.N_CH(N_CH), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
    .q(q), .q_time(q_time), .gamma_start(gamma_start), .gamma_cnt(gamma_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_CH-1:0]    q;
    logic [N_CH*CW-1:0] qt;
    logic               gs;
    logic [CW-1:0]      cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: gamma position and per-channel first-arrival times (-1 = none yet)
  int m_pos, m_mode;
  int ta[N_CH], tb[N_CH], qt[N_CH], prem[N_CH];
  bit fired[N_CH], aprev[N_CH], bprev[N_CH];

  bit              cur_en;
  logic [1:0]      cur_mode;
  logic [N_CH-1:0] cur_a, cur_b;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endfunction

  task automatic model_reset();
    m_pos = 0;
    m_mode = 0;
    for (int i = 0; i < N_CH; i++) begin
      ta[i] = -1; tb[i] = -1; qt[i] = 0; prem[i] = 0;
      fired[i] = 0; aprev[i] = 0; bprev[i] = 0;
    end
  endtask

  // Called just after a rising edge: drive this cycle, predict its outputs, advance the model.
  task automatic drive_cycle(bit e, logic [1:0] md, logic [N_CH-1:0] av, logic [N_CH-1:0] bv);
    exp_t x;
    bit gs, ea, eb, newa, newb, fire, earlier;
    en = e; mode = md; a = av; b = bv;
    gs = e && (m_pos == 0);
    x.gs  = gs;
    x.cnt = CW'(m_pos);
    for (int i = 0; i < N_CH; i++) begin
      x.q[i] = (prem[i] > 0) && !gs;
      x.qt[i*CW +: CW] = CW'(qt[i]);
    end
    sbq.push_back(x);
    if (gs) begin
      m_mode = int'(md);
      for (int i = 0; i < N_CH; i++) begin ta[i] = -1; tb[i] = -1; fired[i] = 0; end
    end
    for (int i = 0; i < N_CH; i++) begin
      ea = e && av[i] && !aprev[i];
      eb = e && bv[i] && !bprev[i];
      newa = ea && (ta[i] < 0);
      newb = eb && (tb[i] < 0);
      earlier = (ta[i] >= 0) || (tb[i] >= 0);
      if (newa) ta[i] = m_pos;
      if (newb) tb[i] = m_pos;
      case (m_mode)
        0: fire = newa && (tb[i] < 0 || tb[i] == m_pos);
        1: fire = newa && (tb[i] < 0);
        2: fire = newa && newb;
        default: fire = (newa || newb) && !earlier;
      endcase
      if (fire && !fired[i]) begin
        fired[i] = 1; qt[i] = m_pos; prem[i] = PW;
      end else if (gs) prem[i] = 0;
      else if (prem[i] > 0) prem[i]--;
      aprev[i] = av[i];
      bprev[i] = bv[i];
    end
    if (e) m_pos = (m_pos + 1) % G;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    drive_cycle(cur_en, cur_mode, cur_a, cur_b);
  endtask

  task automatic goto(int p);
    for (int k = 0; k < 3 * G && m_pos != p; k++) tick();
    check("goto_reached", m_pos, p);
  endtask

  task automatic new_gamma(logic [1:0] md);
    cur_mode = md;
    goto(0);
    tick();
  endtask

  always @(negedge clk) begin
    if (rst_n && sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      check("gamma_cnt",   32'(gamma_cnt),   32'(mon_e.cnt));
      check("gamma_start", 32'(gamma_start), 32'(mon_e.gs));
      check("q",           32'(q),           32'(mon_e.q));
      check("q_time",      32'(q_time),      32'(mon_e.qt));
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; a = '0; b = '0;
    cur_en = 1'b1; cur_mode = 2'd0; cur_a = '0; cur_b = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", 32'(q), 0);
    check("rst_qtime", 32'(q_time), 0);
    check("rst_cnt", 32'(gamma_cnt), 0);
    check("rst_gs", 32'(gamma_start), 0);
    rst_n = 1'b1;
    repeat (40) tick();

    // LTE: a@3 then b@7
    new_gamma(2'd0);
    goto(3); cur_a[0] = 1'b1; tick();
    goto(7); cur_b[0] = 1'b1; tick();
    goto(15); cur_a[0] = 1'b0; cur_b[0] = 1'b0; tick();
    check("lte_order_qtime", 32'(q_time[3:0]), 3);
    // LTE swapped order: no fire
    new_gamma(2'd0);
    goto(3); cur_b[0] = 1'b1; tick();
    goto(7); cur_a[0] = 1'b1; tick();
    goto(15); cur_a[0] = 1'b0; cur_b[0] = 1'b0; tick();
    check("lte_swap_qtime", 32'(q_time[3:0]), 3);
    // LTE tie
    new_gamma(2'd0);
    goto(5); cur_a[0] = 1'b1; cur_b[0] = 1'b1; tick();
    goto(15); cur_a[0] = 1'b0; cur_b[0] = 1'b0; tick();
    check("lte_tie_qtime", 32'(q_time[3:0]), 5);
    // LT tie: no fire
    new_gamma(2'd1);
    goto(7); cur_a[0] = 1'b1; cur_b[0] = 1'b1; tick();
    goto(15); cur_a[0] = 1'b0; cur_b[0] = 1'b0; tick();
    check("lt_tie_qtime", 32'(q_time[3:0]), 5);
    // EQ tie
    new_gamma(2'd2);
    goto(6); cur_a[0] = 1'b1; cur_b[0] = 1'b1; tick();
    goto(15); cur_a[0] = 1'b0; cur_b[0] = 1'b0; tick();
    check("eq_tie_qtime", 32'(q_time[3:0]), 6);
    // MIN: b@2 fires before a@9
    new_gamma(2'd3);
    goto(2); cur_b[0] = 1'b1; tick();
    goto(9); cur_a[0] = 1'b1; tick();
    goto(15); cur_a[0] = 1'b0; cur_b[0] = 1'b0; tick();
    check("min_qtime", 32'(q_time[3:0]), 2);

    // Boundary truncation, held input across boundary, re-arm
    new_gamma(2'd0);
    goto(14); cur_a[0] = 1'b1; tick();
    goto(2); cur_a[0] = 1'b0; tick();
    check("held_no_fire_qtime", 32'(q_time[3:0]), 14);
    goto(4); cur_a[0] = 1'b1; tick();
    goto(8); cur_a[0] = 1'b0; tick();
    check("rearm_qtime", 32'(q_time[3:0]), 4);

    // Single fire with repeated toggles
    new_gamma(2'd0);
    for (int k = 0; k < 3; k++) begin
      goto(2 + 4 * k); cur_a[0] = 1'b1; tick();
      goto(4 + 4 * k); cur_a[0] = 1'b0; tick();
    end
    check("single_fire_qtime", 32'(q_time[3:0]), 2);

    // Stall with en=0 mid-pulse; edges during the stall are ignored
    new_gamma(2'd0);
    goto(3); cur_a[0] = 1'b1; tick();
    goto(5);
    cur_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cur_a[2] = ~cur_a[2]; cur_b[1] = ~cur_b[1]; tick();
    end
    cur_en = 1'b1; cur_a = '0; cur_b = '0;
    goto(15); tick();
    check("stall_qtime0", 32'(q_time[3:0]), 3);
    check("stall_qtime2", 32'(q_time[11:8]), 0);

    // Async reset while q[1] is high
    new_gamma(2'd0);
    goto(2); cur_a[1] = 1'b1; tick();
    goto(5);
    check("pre_reset_q1", 32'(q[1]), 1);
    #1;
    rst_n = 1'b0; en = 1'b0; a = '0; b = '0;
    #1;
    check("async_q", 32'(q), 0);
    check("async_qtime", 32'(q_time), 0);
    check("async_cnt", 32'(gamma_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cur_a = '0; cur_b = '0; cur_en = 1'b1; cur_mode = 2'd0;
    rst_n = 1'b1;
    repeat (40) tick();

    // Randomized traffic
    for (int k = 0; k < 1200; k++) begin
      cur_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) cur_mode = 2'($urandom_range(0, 3));
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(0, 5) == 0) cur_a[i] = ~cur_a[i];
        if ($urandom_range(0, 5) == 0) cur_b[i] = ~cur_b[i];
      end
      tick();
    end

    @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
